// File: rtl/sm4_pkg.sv
// sm4_pkg: shared definitions for the iterative SM4 core.
//   state_t  - controller states (IDLE, KEXP, RUN, DONE)
//   FK       - system parameter XORed into the master key
//   ck_word  - round constant CK[i]; byte j = (4i+j)*7 mod 256, byte 0 in the MSBs
//   l_enc    - linear transform L  used by the data rounds
//   l_key    - linear transform L' used by the key schedule
package sm4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEXP = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] l_enc(input logic [31:0] b);
        return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    endfunction

    function automatic logic [31:0] l_key(input logic [31:0] b);
        return b ^ rotl(b, 13) ^ rotl(b, 23);
    endfunction

    // 8-bit arithmetic gives the mod-256 reduction for free.
    function automatic logic [31:0] ck_word(input logic [4:0] i);
        logic [31:0] w;
        logic [7:0]  idx;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            idx = {1'b0, i, 2'b00} + 8'(j);
            w[8*(3-j) +: 8] = idx * 8'd7;
        end
        return w;
    endfunction

endpackage

// File: rtl/SM4.sv
// SM4: the SM4 byte substitution box, purely combinational.
//   x  in  8 - input byte
//   Sb out 8 - substituted byte
module SM4 (
    input  logic [7:0] x,
    output logic [7:0] Sb
);

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    assign Sb = SBOX[x];

endmodule

// File: rtl/sm4_tau.sv
// sm4_tau: SM4 non-linear layer, four parallel S-boxes on a 32-bit word.
//   a in  32 - input word
//   b out 32 - byte-wise substituted word
module sm4_tau (
    input  logic [31:0] a,
    output logic [31:0] b
);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        SM4 u_sbox (
            .x  (a[8*i +: 8]),
            .Sb (b[8*i +: 8])
        );
    end

endmodule

// File: rtl/sm4_iter_core.sv
// sm4_iter_core: iterative SM4 cipher, one round per clock.
// A key handshake runs the 32-round key schedule into a round-key file;
// a data handshake then encrypts or decrypts one block in 32 cycles.
//   clk, rst              - clock, asynchronous active-high reset
//   key_valid/key_ready   - master key handshake, key[127:96] = MK0
//   key_loaded            - a complete round-key set is stored
//   in_valid/in_ready     - data block handshake, in_data[127:96] = X0
//   in_decrypt            - 1 = decrypt, sampled with in_data
//   out_valid/out_ready   - result handshake, out_data = {X35,X34,X33,X32}
module sm4_iter_core
    import sm4_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key,
    output logic         key_loaded,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_decrypt,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    state_t        state_q, state_d;
    logic [4:0]    rnd_q;
    logic          key_loaded_q;
    logic          decrypt_q;
    logic [127:0]  win_q;       // key window K0..K3 in KEXP, data window X0..X3 in RUN
    logic [127:0]  out_data_q;
    logic [31:0]   rk_mem [32];

    logic          load_key, load_data, kexp_step, run_step, last_round;
    logic [31:0]   w0, w1, w2, w3;
    logic [4:0]    rk_idx;
    logic [31:0]   rk_sel, tau_in, tau_out, new_word;

    assign {w0, w1, w2, w3} = win_q;
    assign last_round = (rnd_q == 5'd31);

    // Decryption walks the key file backwards: 31 - rnd is ~rnd in 5 bits.
    assign rk_idx   = decrypt_q ? ~rnd_q : rnd_q;
    assign rk_sel   = (state_q == KEXP) ? ck_word(rnd_q) : rk_mem[rk_idx];
    assign tau_in   = w1 ^ w2 ^ w3 ^ rk_sel;

    sm4_tau u_tau (
        .a (tau_in),
        .b (tau_out)
    );

    assign new_word = w0 ^ ((state_q == KEXP) ? l_key(tau_out) : l_enc(tau_out));

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        load_key  = 1'b0;
        load_data = 1'b0;
        kexp_step = 1'b0;
        run_step  = 1'b0;
        key_ready = 1'b0;
        in_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                key_ready = 1'b1;
                // A key offer wins over a data offer in the same cycle.
                in_ready  = key_loaded_q & ~key_valid;
                if (key_valid) begin
                    load_key = 1'b1;
                    state_d  = KEXP;
                end else if (in_valid && key_loaded_q) begin
                    load_data = 1'b1;
                    state_d   = RUN;
                end
            end
            KEXP: begin
                kexp_step = 1'b1;
                if (last_round) state_d = IDLE;
            end
            RUN: begin
                run_step = 1'b1;
                if (last_round) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd_q        <= '0;
            key_loaded_q <= 1'b0;
            decrypt_q    <= 1'b0;
            win_q        <= '0;
            out_data_q   <= '0;
        end else if (load_key) begin
            win_q        <= key ^ FK;
            key_loaded_q <= 1'b0;
            rnd_q        <= '0;
        end else if (load_data) begin
            win_q     <= in_data;
            decrypt_q <= in_decrypt;
            rnd_q     <= '0;
        end else if (kexp_step || run_step) begin
            win_q <= {w1, w2, w3, new_word};
            rnd_q <= rnd_q + 5'd1;   // wraps 31 -> 0 on the exiting round
            if (kexp_step && last_round) key_loaded_q <= 1'b1;
            if (run_step && last_round) out_data_q <= {new_word, w3, w2, w1};
        end
    end

    // NOTE: the round-key file has no reset; key_loaded gates its use, so
    // its power-up contents never reach the datapath.
    always_ff @(posedge clk) begin
        if (kexp_step) rk_mem[rnd_q] <= new_word;
    end

    assign key_loaded = key_loaded_q;
    assign out_valid  = (state_q == DONE);
    assign out_data   = out_data_q;

endmodule

// File: tb/tb_sm4_iter_core.sv
// tb_sm4_iter_core: self-checking bench for sm4_iter_core.
// Table-driven block vectors with a scoreboard queue, plus directed sequences
// for reset, priority, no-key, backpressure and mid-operation reset.
module tb_sm4_iter_core;

    localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] STD_PT  = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] STD_CT  = 128'h681EDF34D206965E86B3E94F536E4246;
    localparam logic [127:0] KEY2    = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

    localparam logic [2047:0] SBOX_BITS = {
        128'hD690E9FECCE13DB716B614C228FB2C05, 128'h2B679A762ABE04C3AA44132649860699,
        128'h9C4250F491EF987A33540B43EDCFAC62, 128'hE4B31CA9C908E89580DF94FA758F3FA6,
        128'h4707A7FCF37317BA83593C19E6854FA8, 128'h686B81B27164DA8BF8EB0F4B70569D35,
        128'h1E240E5E6358D1A225227C3B01217887, 128'hD40046579FD327524C3602E7A0C4C89E,
        128'hEABF8AD240C738B5A3F7F2CEF96115A1, 128'hE0AE5DA49B341A55AD933230F58CB1E3,
        128'h1DF6E22E8266CA60C02923AB0D534E6F, 128'hD5DB3745DEFD8E2F03FF6A726D6C5B51,
        128'h8D1BAF92BBDDBC7F11D95C411F105AD8, 128'h0AC13188A5CD7BBD2D74D012B8E5B4B0,
        128'h8969974A0C96777E65B9F109C56EC684, 128'h18F07DEC3ADC4D2079EE5F3ED7CB3948
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid, key_ready, key_loaded;
    logic [127:0] key;
    logic         in_valid, in_ready, in_decrypt;
    logic [127:0] in_data;
    logic         out_valid, out_ready;
    logic [127:0] out_data;

    int           checks = 0;
    int           errors = 0;
    logic [127:0] exp_q [$];
    logic [127:0] cur_key;

    always #5 clk = ~clk;

    sm4_iter_core dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key        (key),
        .key_loaded (key_loaded),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_decrypt (in_decrypt),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    // ---------------- software reference model ----------------
    function automatic logic [7:0] m_sb(input logic [7:0] x);
        return SBOX_BITS[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] m_tau(input logic [31:0] w);
        return {m_sb(w[31:24]), m_sb(w[23:16]), m_sb(w[15:8]), m_sb(w[7:0])};
    endfunction

    function automatic logic [31:0] m_rot(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] sm4_model(input logic [127:0] k, input logic [127:0] blk,
                                               input logic dec);
        logic [31:0]  kw [36];
        logic [31:0]  rk [32];
        logic [31:0]  x  [36];
        logic [31:0]  t, ck;
        logic [127:0] kf;
        kf = k ^ 128'hA3B1BAC656AA3350677D9197B27022DC;
        for (int i = 0; i < 4; i++) begin
            kw[i] = kf[127 - 32*i -: 32];
            x[i]  = blk[127 - 32*i -: 32];
        end
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) ck[31 - 8*j -: 8] = 8'(((4*i + j) * 7) % 256);
            t = m_tau(kw[i+1] ^ kw[i+2] ^ kw[i+3] ^ ck);
            rk[i] = kw[i] ^ t ^ m_rot(t, 13) ^ m_rot(t, 23);
            kw[i+4] = rk[i];
        end
        for (int i = 0; i < 32; i++) begin
            t = m_tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ (dec ? rk[31-i] : rk[i]));
            x[i+4] = x[i] ^ t ^ m_rot(t, 2) ^ m_rot(t, 10) ^ m_rot(t, 18) ^ m_rot(t, 24);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_loaded(input string name);
        int n = 0;
        while (!key_loaded && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_key_latency"}, 128'(n), 128'd32);
    endtask

    task automatic load_key(input logic [127:0] k, input string name);
        int n = 0;
        key = k;
        key_valid = 1'b1;
        #1;
        while (!key_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_key_ready"}, 128'(key_ready), 128'd1);
        @(posedge clk); #1;
        key_valid = 1'b0;
        wait_loaded(name);
        cur_key = k;
    endtask

    task automatic send_block(input logic [127:0] d, input logic dec, input logic [127:0] exp,
                              input string name);
        int n = 0;
        in_data = d;
        in_decrypt = dec;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_accept"}, 128'(in_ready), 128'd1);
        if (in_ready) begin
            @(posedge clk); #1;
            exp_q.push_back(exp);
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input int hold, input logic offer_key, input string name);
        int           n = 0;
        int           busy_hs = 0;
        int           bad = 0;
        logic [127:0] exp, held;
        if (offer_key) begin
            key = KEY2;
            key_valid = 1'b1;
        end
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (key_ready || in_ready) busy_hs++;
        end
        key_valid = 1'b0;
        check({name, "_latency"}, 128'(n), 128'd32);
        check({name, "_busy_handshake"}, 128'(busy_hs), 128'd0);
        if (!out_valid) return;
        check({name, "_scoreboard"}, 128'(exp_q.size() != 0), 128'd1);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check({name, "_data"}, out_data, exp);
        held = out_data;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!out_valid || out_data !== held || in_ready || key_ready) bad++;
        end
        if (hold > 0) check({name, "_stall"}, 128'(bad), 128'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_release"}, {126'd0, in_ready, out_valid}, 128'b10);
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [127:0] key;
        logic [127:0] data;
        logic         dec;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int hi;
        vecs[0] = '{STD_KEY, STD_PT, 1'b0, STD_CT};
        vecs[1] = '{STD_KEY, STD_CT, 1'b1, STD_PT};
        vecs[2] = '{STD_KEY, 128'd0, 1'b0, sm4_model(STD_KEY, 128'd0, 1'b0)};
        vecs[3] = '{KEY2, STD_PT, 1'b0, sm4_model(KEY2, STD_PT, 1'b0)};
        vecs[4] = '{KEY2, {128{1'b1}}, 1'b0, sm4_model(KEY2, {128{1'b1}}, 1'b0)};
        vecs[5] = '{KEY2, sm4_model(KEY2, 128'h00112233445566778899AABBCCDDEEFF, 1'b0), 1'b1,
                    128'h00112233445566778899AABBCCDDEEFF};

        rst = 1'b1;
        key_valid = 1'b0;
        key = '0;
        in_valid = 1'b0;
        in_decrypt = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        cur_key = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_key_ready", 128'(key_ready), 128'd1);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_key_loaded", 128'(key_loaded), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        rst = 1'b0;

        // Data offered before any key is never accepted.
        in_data = STD_PT;
        in_valid = 1'b1;
        hi = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (in_ready || out_valid || !key_ready) hi++;
        end
        in_valid = 1'b0;
        check("nokey_never_accepted", 128'(hi), 128'd0);

        // Standard key and its first/last round keys.
        load_key(STD_KEY, "std");
        check("rk0", 128'(dut.rk_mem[0]), 128'h0F12186F9);
        check("rk31", 128'(dut.rk_mem[31]), 128'h09124A012);

        // Table-driven vectors, reloading the key whenever it changes.
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].key !== cur_key) load_key(vecs[i].key, $sformatf("v%0d", i));
            send_block(vecs[i].data, vecs[i].dec, vecs[i].exp, $sformatf("v%0d", i));
            collect(0, 1'b0, $sformatf("v%0d", i));
        end

        // Key and data offered together: key wins, data is not taken.
        key = STD_KEY;
        key_valid = 1'b1;
        in_data = STD_PT;
        in_valid = 1'b1;
        #1;
        check("prio_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        key_valid = 1'b0;
        in_valid = 1'b0;
        check("prio_key_taken", {126'd0, key_loaded, key_ready}, 128'd0);
        wait_loaded("prio");
        cur_key = STD_KEY;
        check("prio_no_output", 128'(out_valid), 128'd0);

        // Backpressure with a key offered mid-block.
        send_block(STD_PT, 1'b0, STD_CT, "bp");
        collect(10, 1'b1, "bp");

        // Reset in the middle of RUN, then recover.
        send_block(STD_PT, 1'b0, STD_CT, "mid");
        repeat (17) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_outputs", {124'd0, key_ready, in_ready, key_loaded, out_valid}, 128'b1000);
        check("midrst_out_data", out_data, 128'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        load_key(STD_KEY, "reload");
        send_block(STD_PT, 1'b0, STD_CT, "reload");
        collect(0, 1'b0, "reload");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
